// File: rtl/guess_datapath.sv
// guess_datapath: word storage, letter-reveal compare engine, hangman part
// counter and round countdown for a hangman game. A separate controller
// sequences the pulses below; this block only keeps state and scores guesses.
//
// Pulse protocol: ld, word_done, compare, draw and clear are one-cycle
// strobes sampled on the rising clk edge. A compare is accepted only in IDLE
// while locked. Exactly word_len+1 cycles after the compare cycle, cmp_done is
// high for one cycle. match/hit_count are valid from that cycle and hold until
// the next cmp_done. No back-pressure exists; strobes arriving while the
// engine is busy are dropped.
module guess_datapath #(
  parameter int MAX_LEN       = 16,        // word depth in letters (<= 31)
  parameter int TICKS_PER_SEC = 50000000,  // clk cycles per countdown second
  parameter int TIME_SEC      = 30         // countdown start value, 1..63
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld,
  input  logic [4:0]         letter_in,
  input  logic               word_done,
  input  logic               timecount,
  input  logic               compare,
  input  logic [4:0]         guess,
  input  logic               draw,
  input  logic               clear,
  output logic               cmp_done,
  output logic               match,
  output logic [4:0]         hit_count,
  output logic [4:0]         remain,
  output logic [MAX_LEN-1:0] reveal,
  output logic [4:0]         word_len,
  output logic               locked,
  output logic [3:0]         part,
  output logic               complete,
  output logic               win,
  output logic               timeout,
  output logic [5:0]         sec_left
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Letter storage is not reset; word_len alone decides which entries count.
  logic [4:0]         r_mem [MAX_LEN];

  state_t             r_state;
  logic [4:0]         r_idx;
  logic [4:0]         r_guess;
  logic [4:0]         r_acc;
  logic [4:0]         r_word_len;
  logic [4:0]         r_remain;
  logic [MAX_LEN-1:0] r_reveal;
  logic               r_locked;
  logic               r_cmp_done;
  logic               r_match;
  logic [4:0]         r_hit_count;
  logic [3:0]         r_part;
  logic [PW-1:0]      r_presc;
  logic [5:0]         r_sec;
  logic               r_timeout;

  logic               w_valid_letter;
  logic               w_ld_ok;
  logic [IW-1:0]      w_wr_idx;
  logic [IW-1:0]      w_rd_idx;
  logic               w_hit;
  logic [4:0]         w_acc_next;
  logic               w_last;
  logic               w_cnt_en;
  logic               w_presc_wrap;

  assign w_valid_letter = (letter_in != 5'd0) && (letter_in <= 5'd26);
  // word_done takes precedence over ld in the same cycle.
  assign w_ld_ok  = ld && !word_done && !r_locked && w_valid_letter &&
                    (r_word_len < 5'(MAX_LEN));
  assign w_wr_idx = r_word_len[IW-1:0];
  assign w_rd_idx = r_idx[IW-1:0];

  // A position counts only once: it must match and still be hidden.
  assign w_hit      = (r_mem[w_rd_idx] == r_guess) && !r_reveal[w_rd_idx];
  assign w_acc_next = r_acc + {4'd0, w_hit};
  assign w_last     = (r_idx == (r_word_len - 5'd1));

  assign w_cnt_en     = r_locked && timecount && !r_timeout;
  assign w_presc_wrap = (r_presc == PW'(TICKS_PER_SEC - 1));

  // Letter storage write port.
  always_ff @(posedge clk) begin
    if (w_ld_ok && !clear) begin
      r_mem[w_wr_idx] <= letter_in;
    end
  end

  // Word bookkeeping and the compare FSM (IDLE -> SCAN -> DONE -> IDLE).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_idx       <= 5'd0;
      r_guess     <= 5'd0;
      r_acc       <= 5'd0;
      r_word_len  <= 5'd0;
      r_remain    <= 5'd0;
      r_reveal    <= '0;
      r_locked    <= 1'b0;
      r_cmp_done  <= 1'b0;
      r_match     <= 1'b0;
      r_hit_count <= 5'd0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_idx       <= 5'd0;
      r_guess     <= 5'd0;
      r_acc       <= 5'd0;
      r_word_len  <= 5'd0;
      r_remain    <= 5'd0;
      r_reveal    <= '0;
      r_locked    <= 1'b0;
      r_cmp_done  <= 1'b0;
      r_match     <= 1'b0;
      r_hit_count <= 5'd0;
    end else begin
      r_cmp_done <= 1'b0;
      if (w_ld_ok) begin
        r_word_len <= r_word_len + 5'd1;
        r_remain   <= r_remain + 5'd1;
      end
      if (word_done && (r_word_len != 5'd0)) begin
        r_locked <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (compare && r_locked) begin
            r_guess <= guess;
            r_acc   <= 5'd0;
            r_idx   <= 5'd0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            r_reveal[w_rd_idx] <= 1'b1;
          end
          r_acc <= w_acc_next;
          if (w_last) begin
            // Results are registered on entry so they line up with cmp_done.
            r_state     <= ST_DONE;
            r_cmp_done  <= 1'b1;
            r_hit_count <= w_acc_next;
            r_match     <= (w_acc_next != 5'd0);
            r_remain    <= r_remain - w_acc_next;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Hangman part counter, saturating at 9.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_part <= 4'd0;
    end else if (clear) begin
      r_part <= 4'd0;
    end else if (draw && (r_part < 4'd9)) begin
      r_part <= r_part + 4'd1;
    end
  end

  // Round countdown: prescaler wraps once per second; timeout is sticky.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc   <= '0;
      r_sec     <= 6'(TIME_SEC);
      r_timeout <= 1'b0;
    end else if (clear) begin
      r_presc   <= '0;
      r_sec     <= 6'(TIME_SEC);
      r_timeout <= 1'b0;
    end else if (w_cnt_en) begin
      if (w_presc_wrap) begin
        r_presc <= '0;
        r_sec   <= r_sec - 6'd1;
        if (r_sec == 6'd1) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign cmp_done  = r_cmp_done;
  assign match     = r_match;
  assign hit_count = r_hit_count;
  assign remain    = r_remain;
  assign reveal    = r_reveal;
  assign word_len  = r_word_len;
  assign locked    = r_locked;
  assign part      = r_part;
  assign complete  = (r_part == 4'd9);
  assign win       = r_locked && (r_word_len != 5'd0) && (r_remain == 5'd0);
  assign timeout   = r_timeout;
  assign sec_left  = r_sec;

endmodule

// File: doc/guess_datapath.md
GUESS_DATAPATH -- requirements
Module: guess_datapath

Interface
REQ-001 Parameter MAX_LEN, default 16: word storage depth, in letters.
REQ-002 Parameter TICKS_PER_SEC, default 50000000: clk cycles per countdown second.
REQ-003 Parameter TIME_SEC, default 30: countdown start value, in seconds (1..63).
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port resetn  in  1  one clock; reset is asynchronous and active-low.
REQ-006 Port ld  in  1  one-cycle pulse; append letter_in to the word.
REQ-007 Port letter_in  in  5  letter code; 1=A .. 26=Z; 0 and 27..31 invalid.
REQ-008 Port word_done  in  1  pulse; lock the word and arm the round.
REQ-009 Port timecount  in  1  level; enables the countdown.
REQ-010 Port compare  in  1  pulse; start evaluating guess.
REQ-011 Port guess  in  5  guessed letter code; sampled on the compare cycle.
REQ-012 Port draw  in  1  pulse; advance the hangman part.
REQ-013 Port clear  in  1  synchronous round restart.
REQ-014 Port cmp_done  out  1  one-cycle pulse; compare result valid.
REQ-015 Port match  out  1  at least one new position revealed by the last compare.
REQ-016 Port hit_count  out  5  new positions revealed by the last compare.
REQ-017 Port remain  out  5  unrevealed letters.
REQ-018 Port reveal  out  MAX_LEN  bit i=1 means position i is revealed.
REQ-019 Port word_len  out  5  stored letters.
REQ-020 Port locked  out  1  word frozen.
REQ-021 Port part  out  4  hangman parts drawn, 0..9.
REQ-022 Port complete  out  1  part==9.
REQ-023 Port win  out  1  locked and word_len>0 and remain==0.
REQ-024 Port timeout  out  1  countdown expired; sticky.
REQ-025 Port sec_left  out  6  seconds remaining.

Function
REQ-026 ld when unlocked, letter_in is 1..26, and word_len<MAX_LEN: store the letter at index word_len; increment word_len and remain the next cycle. Otherwise ld is ignored.
REQ-027 word_done sets locked; it is ignored when word_len==0. When ld and word_done occur in the same cycle, word_done wins and ld is dropped.
REQ-028 Compare FSM states: IDLE, SCAN, DONE.
- IDLE->SCAN: on compare while locked, latch guess, zero the hit accumulator, set index=0.
- compare is ignored in SCAN, in DONE, or while unlocked.
REQ-029 SCAN: one position per cycle. When stored[index]==guess and reveal[index]==0, set reveal[index] and increment the hit accumulator. SCAN->DONE after index word_len-1.
REQ-030 DONE, one cycle:
- cmp_done=1
- hit_count=accumulator
- match=(accumulator!=0)
- remain decremented by the accumulator
- then ->IDLE
Latency from the compare cycle to cmp_done is word_len+1 cycles.
REQ-031 match and hit_count hold their values until the next DONE.
REQ-032 A guess of an already-revealed letter, or an invalid code, gives match=0 and hit_count=0.
REQ-033 draw increments part when part<9; it saturates at 9. complete is combinational (part==9).
REQ-034 Countdown runs while locked & timecount & !timeout.
- A prescaler counts 0..TICKS_PER_SEC-1; on wrap, sec_left decrements.
- When sec_left reaches 0, timeout=1 on that same edge.
- The prescaler holds its value when the countdown is not enabled.
REQ-035 timeout stays 1 until clear or reset; sec_left holds 0.
REQ-036 clear (highest priority, synchronous) has the same effect as reset, except storage contents need not be cleared. It aborts a SCAN without a cmp_done pulse.
REQ-037 win, complete, and timeout do not block compare or draw; arbitration belongs to the controller.

Reset
REQ-038 resetn=0 drives, asynchronously, the following and holds them:
- FSM=IDLE
- word_len=0, remain=0, reveal=0
- locked=0, part=0
- cmp_done=0, match=0, hit_count=0
- timeout=0, sec_left=TIME_SEC, prescaler=0
REQ-039 Deassertion mid-SCAN resumes from IDLE; there is no spurious cmp_done.

Verification (TICKS_PER_SEC=4, TIME_SEC=3, MAX_LEN=16)
REQ-040 Load: ld with codes 2,1,14,1,14,1 (BANANA), then word_done -> word_len=6, remain=6, locked=1.
REQ-041 Compare with guess=1 -> cmp_done exactly 7 cycles after the compare cycle, hit_count=3, match=1, reveal=0x002A, remain=3. Repeat guess=1 -> hit_count=0, match=0, remain=3.
REQ-042 Compare with guess=26 -> match=0. Then guess=2 and guess=14 -> remain=0, win=1.
REQ-043 Ten draw pulses -> part=9, complete=1 after the ninth pulse, and the tenth pulse has no effect.
REQ-044 timecount=1 for 12 cycles -> sec_left steps 3,2,1,0 every 4 cycles and timeout=1. Then clear -> timeout=0, sec_left=3, locked=0.
REQ-045 Edge cases:
- ld with letter_in=0, and a 17th ld, -> ignored.
- ld together with word_done -> word_len is unchanged.
- resetn=0 mid-SCAN -> all outputs at reset values, no cmp_done.
